p_skid_pipe_reg: RTL and testbench

- Parametrised successor to the fixed-type pipeline stage register.
- Replaces the single `load` enable with a valid/ready handshake on both sides.
- Has a two-entry skid buffer, so `in_ready` is a registered function of state and never depends combinationally on `out_ready`.
- Sits between pipeline stages (e.g. I-cache response to decode); adds a synchronous flush for branch/exception squash.

---
 rtl/p_skid_pipe_reg.sv | 92 +++++++++
 tb/tb_p_skid_pipe_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/p_skid_pipe_reg.sv
// Pipeline stage register with valid/ready handshake on both sides and a two-entry skid buffer.
// in_ready depends only on the registered state and flush, never on out_ready.
module p_skid_pipe_reg #(
    parameter int unsigned         WIDTH      = 32,
    parameter logic [WIDTH-1:0]    RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             acc;
    logic             emit;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL) && !flush;
    assign out_data  = main_q;
    assign occupancy = (state_q == FULL) ? 2'd2 :
                       (state_q == BUSY) ? 2'd1 : 2'd0;

    assign acc  = in_valid & in_ready;
    assign emit = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (acc && emit) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is always the younger one, so it becomes the new head.
                    if (emit) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            // NOTE: the two data registers are few enough to reset explicitly, giving a known out_data after reset.
            main_q  <= RESET_DATA;
            skid_q  <= RESET_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_p_skid_pipe_reg.sv
// Self-checking bench for p_skid_pipe_reg: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a random streaming run.
module tb_p_skid_pipe_reg;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [1:0]       occupancy;

    int checks = 0;
    int errors = 0;

    // Reference model: the held entries are simply a FIFO queue of at most two words.
    logic [WIDTH-1:0] mq[$];
    logic             m_acc = 1'b0;
    logic [WIDTH-1:0] dut_log[$];
    bit               chk_en = 1'b0;

    p_skid_pipe_reg #(.WIDTH(WIDTH), .RESET_DATA('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit acc_now;
        bit emit_now;
        acc_now  = in_valid && (mq.size() < 2) && !flush && !rst;
        emit_now = (mq.size() > 0) && out_ready && !rst;
        m_acc    = acc_now;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (emit_now) void'(mq.pop_front());
            if (acc_now)  mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("m_in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2) && !flush});
            check("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
            check("m_occupancy", {30'd0, occupancy}, mq.size());
            if (mq.size() != 0) check("m_out_data", out_data, mq[0]);
            if (out_valid && out_ready) dut_log.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int widx;
        int start;
        int cyc;
        logic [WIDTH-1:0] base;

        // Reset with a valid word offered: it must not be captured.
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        chk_en = 1'b1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        check("rst_out_data",  out_data, 32'h0);
        tick();
        check("rst_no_accept", {30'd0, occupancy}, 32'd0);

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            check("stream_data", out_data, i);
            check("stream_occ",  {30'd0, occupancy}, 32'd1);
            check("stream_rdy",  {31'd0, in_ready},  32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain", {30'd0, occupancy}, 32'd0);

        // Backpressure fills the skid entry; a third word waits.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        check("bp_occ_full", {30'd0, occupancy}, 32'd2);
        check("bp_rdy_low",  {31'd0, in_ready},  32'd0);
        in_data = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_occ",  {30'd0, occupancy}, 32'd2);
            check("bp_hold_data", out_data, 32'hA);
        end
        out_ready = 1'b1;
        tick();
        check("bp_emit_b", out_data, 32'hB);
        check("bp_occ_b",  {30'd0, occupancy}, 32'd1);
        tick();
        check("bp_emit_c", out_data, 32'hC);
        check("bp_occ_c",  {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drain", {30'd0, occupancy}, 32'd0);

        // Flush while FULL with a word offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h10; tick();
        in_data = 32'h11; tick();
        check("fl_occ_full", {30'd0, occupancy}, 32'd2);
        flush = 1'b1; in_data = 32'h12;
        #1;
        check("fl_rdy_low", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ",   {30'd0, occupancy}, 32'd0);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("fl_no_12", {31'd0, out_valid}, 32'd0);

        // Simultaneous accept and emit in BUSY.
        in_valid = 1'b1; in_data = 32'h20; tick();
        check("ae_head", out_data, 32'h20);
        in_data = 32'h21; out_ready = 1'b1; tick();
        check("ae_data", out_data, 32'h21);
        check("ae_occ",  {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0; tick();

        // Reset from FULL discards both entries and restores RESET_DATA.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h30; tick();
        in_data = 32'h31; tick();
        rst = 1'b1; in_valid = 1'b0; tick();
        rst = 1'b0;
        check("mr_occ",  {30'd0, occupancy}, 32'd0);
        check("mr_data", out_data, 32'h0);

        // Random traffic: 1000 words must leave in order, none lost or duplicated.
        base  = 32'h5000_0000;
        widx  = 0;
        cyc   = 0;
        start = dut_log.size();
        while ((widx < 1000) && (cyc < 20000)) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = base + widx;
            out_ready = $urandom_range(0, 1) == 1;
            tick();
            if (m_acc) widx++;
            cyc++;
        end
        check("rand_sent", widx, 32'd1000);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rand_count", dut_log.size() - start, 32'd1000);
        for (int i = 0; i < 1000; i++) begin
            if (start + i < dut_log.size())
                check("rand_order", dut_log[start + i], base + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
